// File: rtl/seg7_scan_driver_if.sv
// Display bus for seg7_scan_driver: value/dp/load from the datapath, segment and anode pins back.
interface seg7_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   dp_mask;
   logic                    load;
   logic [6:0]              seg;
   logic                    dp;
   logic [NUM_DIGITS-1:0]   an;
   logic                    frame_done;

   modport master (output value, dp_mask, load, input seg, dp, an, frame_done);
   modport slave  (input value, dp_mask, load, output seg, dp, an, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex seven-segment scanner with double-buffered value, guard time and decimal points.
// Optional leading-zero blanking is built when LEADING_ZERO_BLANK_EN is defined.
module seg7_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   seg7_scan_driver_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic POL = (ACTIVE_LOW != 0);

   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
   end
   if (GUARD_CYCLES < 0) begin : g_bad_guard
      $error("seg7_scan_driver: GUARD_CYCLES must be >= 0");
   end
   if (REFRESH_DIV < GUARD_CYCLES + 1) begin : g_bad_div
      $error("seg7_scan_driver: REFRESH_DIV must be >= GUARD_CYCLES+1");
   end
   if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_pol
      $error("seg7_scan_driver: ACTIVE_LOW must be 0 or 1");
   end

   typedef enum logic {GUARD_S, DRIVE_S} phase_t;

   phase_t                  state_reg, state_next;
   logic                    run_reg;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic                    boundary;
   logic                    in_guard;
   logic [4*NUM_DIGITS-1:0] pend_val_reg, pend_val_next;
   logic [NUM_DIGITS-1:0]   pend_dp_reg, pend_dp_next;
   logic [4*NUM_DIGITS-1:0] act_val_reg, act_val_next;
   logic [NUM_DIGITS-1:0]   act_dp_reg, act_dp_next;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [3:0]              nib;
   logic [6:0]              lit;
   logic [NUM_DIGITS-1:0]   an_on;
   logic                    dp_on;
   logic [6:0]              seg_reg, seg_next;
   logic                    dp_reg, dp_next;
   logic [NUM_DIGITS-1:0]   an_reg, an_next;
   logic                    frame_done_reg, frame_done_next;

   // Active-high lit pattern {g,f,e,d,c,b,a}; polarity is applied afterwards.
   function automatic logic [6:0] hex_lit(input logic [3:0] n);
      case (n)
         4'h0: hex_lit = 7'h3F;
         4'h1: hex_lit = 7'h06;
         4'h2: hex_lit = 7'h5B;
         4'h3: hex_lit = 7'h4F;
         4'h4: hex_lit = 7'h66;
         4'h5: hex_lit = 7'h6D;
         4'h6: hex_lit = 7'h7D;
         4'h7: hex_lit = 7'h07;
         4'h8: hex_lit = 7'h7F;
         4'h9: hex_lit = 7'h6F;
         4'hA: hex_lit = 7'h77;
         4'hB: hex_lit = 7'h7C;
         4'hC: hex_lit = 7'h39;
         4'hD: hex_lit = 7'h5E;
         4'hE: hex_lit = 7'h79;
         default: hex_lit = 7'h71;
      endcase
   endfunction

   // The first edge after reset parks the scan on slot 0, cnt 0 instead of advancing.
   always_comb begin
      cnt_next = cnt_reg;
      idx_next = idx_reg;
      boundary = 1'b0;
      if (!run_reg) begin
         cnt_next = '0;
         idx_next = '0;
      end else if (cnt_reg == CNT_LAST) begin
         cnt_next = '0;
         if (idx_reg == IDX_LAST) begin
            idx_next = '0;
            boundary = 1'b1;
         end else begin
            idx_next = idx_reg + 1'b1;
         end
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   // A load on the boundary cycle flows through pending straight into active.
   always_comb begin
      pend_val_next = bus.load ? bus.value   : pend_val_reg;
      pend_dp_next  = bus.load ? bus.dp_mask : pend_dp_reg;
      act_val_next  = boundary ? pend_val_next : act_val_reg;
      act_dp_next   = boundary ? pend_dp_next  : act_dp_reg;
   end

   if (GUARD_CYCLES == 0) begin : g_no_guard
      assign in_guard = 1'b0;
   end else begin : g_guard
      localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD_CYCLES);
      assign in_guard = (cnt_next < GUARD_CNT);
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic above_zero;
   always_comb begin
      blank_mask = '0;
      above_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         above_zero    = above_zero && (act_val_next[4*i +: 4] == 4'd0) && !act_dp_next[i];
         blank_mask[i] = above_zero;
      end
   end
`else
   assign blank_mask = '0;
`endif

   // Outputs are decoded from next-cycle scan position so the registered pins match cnt/idx.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         GUARD_S: if (!in_guard) state_next = DRIVE_S;
         DRIVE_S: if (in_guard)  state_next = GUARD_S;
         default: state_next = GUARD_S;
      endcase

      nib   = act_val_next[{idx_next, 2'b00} +: 4];
      lit   = '0;
      an_on = '0;
      dp_on = 1'b0;
      if (state_next == DRIVE_S) begin
         an_on = NUM_DIGITS'(1) << idx_next;
         if (!blank_mask[idx_next]) begin
            lit   = hex_lit(nib);
            dp_on = act_dp_next[idx_next];
         end
      end
      seg_next        = lit ^ {7{POL}};
      an_next         = an_on ^ {NUM_DIGITS{POL}};
      dp_next         = dp_on ^ POL;
      frame_done_next = (idx_next == IDX_LAST) && (cnt_next == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= GUARD_S;
         run_reg        <= 1'b0;
         cnt_reg        <= '0;
         idx_reg        <= '0;
         pend_val_reg   <= '0;
         pend_dp_reg    <= '0;
         act_val_reg    <= '0;
         act_dp_reg     <= '0;
         seg_reg        <= {7{POL}};
         dp_reg         <= POL;
         an_reg         <= {NUM_DIGITS{POL}};
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         run_reg        <= 1'b1;
         cnt_reg        <= cnt_next;
         idx_reg        <= idx_next;
         pend_val_reg   <= pend_val_next;
         pend_dp_reg    <= pend_dp_next;
         act_val_reg    <= act_val_next;
         act_dp_reg     <= act_dp_next;
         seg_reg        <= seg_next;
         dp_reg         <= dp_next;
         an_reg         <= an_next;
         frame_done_reg <= frame_done_next;
      end
   end

   assign bus.seg        = seg_reg;
   assign bus.dp         = dp_reg;
   assign bus.an         = an_reg;
   assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (4 digits, 8-cycle slots, 2 guard cycles, active-low pins).
// Honors LEADING_ZERO_BLANK_EN in its reference model and vector table.
module tb_seg7_scan_driver;
   localparam int ND = 4;
   localparam int RD = 8;
   localparam int GC = 2;
   localparam int FR = ND * RD;
   localparam int NV = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   seg7_scan_driver #(
      .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      logic [15:0]     value;
      logic [3:0]      dp;
      logic [3:0][6:0] exp_seg;
      logic [3:0]      exp_dp;
   } vec_t;

   vec_t vecs [NV];
   string lit_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   int n_tests = 0;
   int n_fail = 0;
   int t = 0;
   bit started = 0;
   logic [15:0] m_pend_v = '0, m_act_v = '0;
   logic [3:0]  m_pend_dp = '0, m_act_dp = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, t);
      end
   endtask

   function automatic logic [6:0] lit_mask(input int n);
      logic [6:0] m = '0;
      string s = lit_tbl[n];
      for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 97] = 1'b1;
      return m;
   endfunction

   function automatic int msd();
      int m = 0;
      for (int i = 0; i < ND; i++)
         if (((m_act_v >> (4 * i)) & 16'hF) != 0 || m_act_dp[i]) m = i;
      return m;
   endfunction

   // Expected {an, seg, dp, frame_done} for scan cycle tt given the model's active buffer.
   function automatic logic [12:0] expect_out(input int tt);
      int c = tt % RD;
      int d = (tt / RD) % ND;
      logic [3:0] an_e = 4'hF;
      logic [6:0] seg_e = 7'h7F;
      logic dp_e = 1'b1;
      logic fd = ((tt % FR) == FR - 1);
      bit blank = 0;
      if (c >= GC) begin
         an_e = ~(4'b0001 << d);
`ifdef LEADING_ZERO_BLANK_EN
         blank = (d > msd());
`endif
         if (!blank) begin
            seg_e = ~lit_mask(int'((m_act_v >> (4 * d)) & 16'hF));
            dp_e  = ~m_act_dp[d];
         end
      end
      return {an_e, seg_e, dp_e, fd};
   endfunction

   task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] m);
      bit boundary;
      bus.load = ld;
      bus.value = v;
      bus.dp_mask = m;
      @(posedge clk);
      boundary = started && ((t % FR) == FR - 1);
      if (ld) begin
         m_pend_v = v;
         m_pend_dp = m;
      end
      if (boundary) begin
         m_act_v = m_pend_v;
         m_act_dp = m_pend_dp;
      end
      if (started) t++;
      else begin
         t = 0;
         started = 1;
      end
      #1;
      bus.load = 1'b0;
      check("scan", {bus.an, bus.seg, bus.dp, bus.frame_done}, expect_out(t));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_now", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold", {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      started = 0;
      t = 0;
      m_pend_v = '0; m_act_v = '0; m_pend_dp = '0; m_act_dp = '0;
      rst_n = 1'b1;
   endtask

   task automatic align(input int phase);
      for (int i = 0; i < 2 * FR && (t % FR) != phase; i++) step(0, 16'h0, 4'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, t=%0d", t);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt_a, cnt_b, last_fd;
      logic [3:0] an_e;
      vecs[0] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
`ifdef LEADING_ZERO_BLANK_EN
      vecs[1] = '{16'h00F0, 4'b0100, {7'h7F, 7'h40, 7'h0E, 7'h40}, 4'b1011};
      vecs[5] = '{16'h0050, 4'b0000, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
      vecs[6] = '{16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
`else
      vecs[1] = '{16'h00F0, 4'b0100, {7'h40, 7'h40, 7'h0E, 7'h40}, 4'b1011};
      vecs[5] = '{16'h0050, 4'b0000, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
      vecs[6] = '{16'h0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
`endif
      vecs[2] = '{16'hABCD, 4'b0000, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
      vecs[3] = '{16'h89EF, 4'b1001, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b0110};
      vecs[4] = '{16'h5670, 4'b0010, {7'h12, 7'h02, 7'h78, 7'h40}, 4'b1101};

      bus.load = 1'b0;
      bus.value = '0;
      bus.dp_mask = '0;
      #2;
      do_reset();

      for (int i = 0; i < RD; i++) begin
         step(0, 16'h0, 4'h0);
         check("release_an", bus.an, (i < GC) ? 4'hF : 4'hE);
      end
      $display("[TB] reset/release sequence checked");

      for (int k = 0; k < NV; k++) begin
         align(5);
         step(1, vecs[k].value, vecs[k].dp);
         align(FR - 1);
         for (int i = 0; i < FR; i++) begin
            step(0, 16'h0, 4'h0);
            if ((t % RD) == 4) begin
               an_e = ~(4'b0001 << ((t / RD) % ND));
               check("vec_seg", bus.seg, vecs[k].exp_seg[(t / RD) % ND]);
               check("vec_dp", bus.dp, vecs[k].exp_dp[(t / RD) % ND]);
               check("vec_an", bus.an, an_e);
            end
         end
         $display("[TB] vector %0d value=%h dp_mask=%b", k, vecs[k].value, vecs[k].dp);
      end

      align(3);
      step(1, 16'hAAAA, 4'h0);
      step(0, 16'h0, 4'h0);
      step(0, 16'h0, 4'h0);
      step(1, 16'h5555, 4'h0);
      align(FR - 1);
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < FR; i++) begin
         step(0, 16'h0, 4'h0);
         if (bus.seg == 7'h08) cnt_a++;
         if (bus.seg == 7'h12) cnt_b++;
      end
      check("dbuf_no_A", cnt_a, 0);
      check("dbuf_all_5", cnt_b, ND * (RD - GC));
      $display("[TB] double buffer AAAA then 5555 in one frame");

      align(FR - 1);
      check("fd_boundary", bus.frame_done, 1'b1);
      step(1, 16'h7777, 4'h0);
      cnt_a = 0;
      for (int i = 1; i < FR; i++) begin
         step(0, 16'h0, 4'h0);
         if (bus.seg == 7'h78) cnt_a++;
      end
      check("boundary_load", cnt_a, ND * (RD - GC));
      $display("[TB] load on frame_done cycle 7777");

      last_fd = -1;
      for (int i = 0; i < 3 * FR; i++) begin
         step(0, 16'h0, 4'h0);
         if (bus.frame_done) begin
            if (last_fd >= 0) check("fd_period", t - last_fd, FR);
            last_fd = t;
         end
      end
      $display("[TB] frame_done period");

      align(2 * RD + 5);
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 16'h0, 4'h0);
      check("restart_an", bus.an, 4'hE);
      check("restart_seg", bus.seg, 7'h40);
      $display("[TB] reset at slot 2 cnt 5");

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom));
      end
      $display("[TB] random stimulus 1500 cycles");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
